spongent_msg_feeder: RTL

- Upstream driver for the iterative SPONGENT hash core.
- Accepts a byte stream with valid/ready/last and packs bytes into r-bit blocks.
- Runs the core's busy/data_ready/start_hash handshake, owns the core's reset, and captures the digest into a held output register.
- Messages must be a whole number of blocks; a partial final block is flagged as an error and discarded.

---
 rtl/spongent_pkg.sv | 33 +++
 rtl/byte_packer.sv | 73 +++++++
 rtl/spongent_msg_feeder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spongent_pkg.sv
// Shared types and helpers for the SPONGENT message feeder.
package spongent_pkg;

    // Feeder controller states
    typedef enum logic [2:0] {
        ST_CORE_RST = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_HI  = 3'd3,
        ST_WAIT_LO  = 3'd4,
        ST_FINAL    = 3'd5,
        ST_DONE     = 3'd6
    } feeder_state_e;

    localparam int LANE_W = 8;

    // First byte of a block lands in the least significant lane.
    localparam bit LANE_FIRST_LOW = 1'b1;

    // Bytes per block for a given rate width.
    function automatic int bpb(input int r_bits);
        return r_bits / LANE_W;
    endfunction

    // Bit offset of the lane that receives the idx-th byte of a block.
    function automatic int lane_lsb(input int idx, input int n_lanes);
        if (LANE_FIRST_LOW)
            return idx * LANE_W;
        else
            return (n_lanes - 1 - idx) * LANE_W;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles incoming bytes into an R-bit block and remembers whether the
// block that just completed carried the end-of-message marker.
module byte_packer
    import spongent_pkg::*;
#(
    parameter int R = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr,
    input  logic [7:0]   wr_data,
    input  logic         wr_last,
    output logic [R-1:0] block,
    output logic         last_lane,
    output logic         full,
    output logic         last_seen
);

    localparam int BPB   = bpb(R);
    localparam int IDX_W = (BPB > 1) ? $clog2(BPB) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [R-1:0]     block_q, block_d;
    logic             full_q, full_d;
    logic             last_q, last_d;

    // The next byte written completes the block.
    assign last_lane = (idx_q == IDX_W'(BPB - 1));

    assign block     = block_q;
    assign full      = full_q;
    assign last_seen = last_q;

    // Lane write and index/flag update; clear drops any partial progress
    // but leaves the block contents alone so the core still sees them.
    always_comb begin
        idx_d   = idx_q;
        block_d = block_q;
        full_d  = full_q;
        last_d  = last_q;
        if (clear) begin
            idx_d  = '0;
            full_d = 1'b0;
            last_d = 1'b0;
        end else if (wr) begin
            block_d[lane_lsb(int'(idx_q), BPB) +: LANE_W] = wr_data;
            if (last_lane) begin
                idx_d  = '0;
                full_d = 1'b1;
                last_d = wr_last;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Packer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            block_q <= '0;
            full_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            block_q <= block_d;
            full_q  <= full_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/spongent_msg_feeder.sv
// Byte-stream front end for the iterative SPONGENT core: packs bytes into
// rate-sized blocks, sequences the core handshake and holds the digest.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CORE_RST | pulse core reset for one cycle, start a fresh message
// COLLECT  | accept bytes until a block is complete
// ISSUE    | block ready; strobe data_ready once the core is idle
// WAIT_HI  | wait for the core to report busy for this block
// WAIT_LO  | wait for the core to finish absorbing; block data held
// FINAL    | request finalization, capture digest on end_hash
// DONE     | digest held until the consumer acknowledges it
module spongent_msg_feeder
    import spongent_pkg::*;
#(
    parameter int N     = 256,
    parameter int r     = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             core_rst,
    output logic [r-1:0]     core_data_input,
    output logic             core_data_ready,
    output logic             core_start_hash,
    input  logic             core_busy,
    input  logic             core_end_hash,
    input  logic [N-1:0]     core_digest,
    output logic [N-1:0]     digest,
    output logic             digest_valid,
    input  logic             digest_ack,
    output logic             err_partial,
    output logic [CNT_W-1:0] block_count
);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] block_count_q, block_count_d;
    logic [N-1:0]     digest_q, digest_d;
    logic             digest_valid_q, digest_valid_d;
    logic             first_blk_q, first_blk_d;

    logic pk_clear;
    logic pk_wr;
    logic pk_last_lane;
    logic pk_full;
    logic pk_last_seen;

    byte_packer #(.R(r)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .wr        (pk_wr),
        .wr_data   (s_data),
        .wr_last   (s_last),
        .block     (core_data_input),
        .last_lane (pk_last_lane),
        .full      (pk_full),
        .last_seen (pk_last_seen)
    );

    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign block_count  = block_count_q;

    // Next-state and handshake outputs
    always_comb begin
        state_d         = state_q;
        block_count_d   = block_count_q;
        digest_d        = digest_q;
        digest_valid_d  = digest_valid_q;
        first_blk_d     = first_blk_q;
        s_ready         = 1'b0;
        core_rst        = 1'b0;
        core_data_ready = 1'b0;
        core_start_hash = 1'b0;
        err_partial     = 1'b0;
        pk_clear        = 1'b0;
        pk_wr           = 1'b0;

        unique case (state_q)
            ST_CORE_RST: begin
                core_rst    = 1'b1;
                pk_clear    = 1'b1;
                first_blk_d = 1'b1;
                state_d     = ST_COLLECT;
            end
            ST_COLLECT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    pk_wr = 1'b1;
                    if (pk_last_lane) begin
                        state_d = ST_ISSUE;
                    end else if (s_last) begin
                        // Message ended mid-block: drop it and restart the core.
                        err_partial   = 1'b1;
                        pk_clear      = 1'b1;
                        block_count_d = '0;
                        state_d       = ST_CORE_RST;
                    end
                end
            end
            ST_ISSUE: begin
                if (!core_busy && pk_full) begin
                    core_data_ready = 1'b1;
                    first_blk_d     = 1'b0;
                    // Count restarts at the first block of each message so the
                    // previous message's count stays visible until then.
                    if (first_blk_q)
                        block_count_d = CNT_W'(1);
                    else if (block_count_q != '1)
                        block_count_d = block_count_q + 1'b1;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (core_busy)
                    state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!core_busy) begin
                    if (pk_last_seen) begin
                        state_d = ST_FINAL;
                    end else begin
                        pk_clear = 1'b1;
                        state_d  = ST_COLLECT;
                    end
                end
            end
            ST_FINAL: begin
                core_start_hash = 1'b1;
                if (!core_busy && core_end_hash) begin
                    digest_d       = core_digest;
                    digest_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (digest_ack) begin
                    digest_valid_d = 1'b0;
                    state_d        = ST_CORE_RST;
                end
            end
            default: begin
                state_d = ST_CORE_RST;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_CORE_RST;
            block_count_q  <= '0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            first_blk_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            block_count_q  <= block_count_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            first_blk_q    <= first_blk_d;
        end
    end

endmodule
